// File: rtl/motor_input_debounce.sv
// -----------------------------------------------------------------------------
// motor_input_debounce
//
// Synchronizes and debounces the motor board's mechanical inputs (limit
// switches, push-buttons) before they reach the 4-bit input PIO. Each channel
// is filtered on its own, so the PIO edge-capture logic only ever sees one
// clean transition per real switch movement.
//
// Parameters
//   WIDTH            number of independent input channels
//   DEBOUNCE_CYCLES  stability window N in clk cycles (1..2^CNT_W)
//   CNT_W            per-channel counter width, must hold N-1
//   RESET_LEVEL      level loaded into the synchronizers and outputs at reset
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   raw_in         asynchronous, bouncy pin levels
//   debounced_out  filtered levels, feeds the PIO in_port
//   rise_pulse     one-cycle strobe per accepted 0->1 transition
//   fall_pulse     one-cycle strobe per accepted 1->0 transition
//   busy           channel is qualifying a candidate change
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// motor_input_debounce_ch
//
// One debounce channel: 2-flop synchronizer followed by a STABLE/COUNTING
// filter. A candidate level must be seen on the synchronized input for N+1
// consecutive clocks before it is accepted.
//
// Ports
//   clk, reset_n  clock and asynchronous active-low reset
//   raw           asynchronous pin level
//   level         filtered level
//   rise, fall    registered one-cycle transition strobes
//   busy          high while a candidate change is being qualified
// -----------------------------------------------------------------------------
module motor_input_debounce_ch #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter int   CNT_W           = 16,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic busy
);

   typedef enum logic {
      STABLE   = 1'b0,
      COUNTING = 1'b1
   } state_t;

   // Terminal count. Reaching it means the candidate has now been observed on
   // N+1 consecutive edges (entry edge plus N counting edges).
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer; only s2 is allowed to reach the filter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= RESET_LEVEL;
         s2 <= RESET_LEVEL;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Stability filter. Any return of s2 to the current level during
   // COUNTING throws the candidate away; qualification then restarts from
   // zero the next time s2 differs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= STABLE;
         cnt   <= '0;
         level <= RESET_LEVEL;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            STABLE: begin
               if (s2 != level) begin
                  state <= COUNTING;
                  cnt   <= '0;
               end
            end
            COUNTING: begin
               if (s2 == level) begin
                  state <= STABLE;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  level <= s2;
                  rise  <= s2;
                  fall  <= ~s2;
                  state <= STABLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= STABLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // State is a flop, so busy is glitch-free without an extra register.
   assign busy = (state == COUNTING);

endmodule

module motor_input_debounce #(
   parameter int   WIDTH           = 4,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter int   CNT_W           = 16,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] debounced_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic [WIDTH-1:0] busy
);

   // Channels share nothing but clock and reset.
   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      motor_input_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .RESET_LEVEL     (RESET_LEVEL)
      ) u_ch (
         .clk     (clk),
         .reset_n (reset_n),
         .raw     (raw_in[i]),
         .level   (debounced_out[i]),
         .rise    (rise_pulse[i]),
         .fall    (fall_pulse[i]),
         .busy    (busy[i])
      );
   end

endmodule

// File: tb/tb_motor_input_debounce.sv
// -----------------------------------------------------------------------------
// tb_motor_input_debounce
//
// Directed bench for motor_input_debounce with N=4, WIDTH=4, RESET_LEVEL=0.
// A reference model states the acceptance rule directly: a channel's output
// flips once the input, seen through a 2-clock synchronizer delay, has
// disagreed with the output on N+1 consecutive edges. Hand-computed literal
// checks pin both the DUT and that model at the key cycles.
// -----------------------------------------------------------------------------
module tb_motor_input_debounce;

   localparam int W = 4;
   localparam int N = 4;

   logic         clk     = 1'b0;
   logic         reset_n = 1'b1;
   logic [W-1:0] raw_in  = '0;
   logic [W-1:0] debounced_out;
   logic [W-1:0] rise_pulse;
   logic [W-1:0] fall_pulse;
   logic [W-1:0] busy;

   int total = 0;
   int bad   = 0;

   motor_input_debounce #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (N),
      .CNT_W           (4),
      .RESET_LEVEL     (1'b0)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .raw_in        (raw_in),
      .debounced_out (debounced_out),
      .rise_pulse    (rise_pulse),
      .fall_pulse    (fall_pulse),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [W-1:0] m_out  = '0;
   logic [W-1:0] m_rise = '0;
   logic [W-1:0] m_fall = '0;
   logic [W-1:0] m_busy = '0;
   logic [W-1:0] hist[$];      // raw samples of the last two edges, oldest first
   logic [W-1:0] seen;
   int           run[W];       // consecutive edges where delayed input != output

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_out  = '0;
         m_rise = '0;
         m_fall = '0;
         m_busy = '0;
         hist.delete();
         hist.push_back('0);
         hist.push_back('0);
         for (int i = 0; i < W; i++) run[i] = 0;
      end else begin
         seen = hist[0];
         hist.push_back(raw_in);
         void'(hist.pop_front());
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < W; i++) begin
            if (seen[i] != m_out[i]) run[i]++;
            else run[i] = 0;
            if (run[i] == N + 1) begin
               m_out[i]  = seen[i];
               m_rise[i] = seen[i];
               m_fall[i] = ~seen[i];
               run[i]    = 0;
            end
            m_busy[i] = (run[i] != 0);
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Literal expectation applied to both the DUT and the model.
   task automatic lit(input string name, input logic [W-1:0] dut_v,
                      input logic [W-1:0] mdl_v, input logic [W-1:0] exp);
      chk({name, "_dut"}, 32'(dut_v), 32'(exp));
      chk({name, "_model"}, 32'(mdl_v), 32'(exp));
   endtask

   // Every-cycle comparison against the model, 1 time unit after each edge.
   always begin
      @(posedge clk);
      #1;
      chk("cyc_out",  32'(debounced_out), 32'(m_out));
      chk("cyc_rise", 32'(rise_pulse),    32'(m_rise));
      chk("cyc_fall", 32'(fall_pulse),    32'(m_fall));
      chk("cyc_busy", 32'(busy),          32'(m_busy));
      if ((rise_pulse & fall_pulse) != '0)
         chk("rise_and_fall", 32'(rise_pulse & fall_pulse), 32'd0);
   end

   // Advance n active edges, landing 1 time unit after the last one.
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // ---------------- directed stimulus ----------------
   initial begin
      // Reset
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      edges(20);
      lit("reset_out",  debounced_out, m_out,  4'b0000);
      lit("reset_busy", busy,          m_busy, 4'b0000);

      // Clean step on channel 0
      @(negedge clk);
      raw_in[0] = 1'b1;
      edges(2);
      lit("step_busy_e2", busy, m_busy, 4'b0000);
      edges(1);
      lit("step_busy_e3", busy, m_busy, 4'b0001);
      edges(3);
      lit("step_busy_e6", busy,          m_busy, 4'b0001);
      lit("step_out_e6",  debounced_out, m_out,  4'b0000);
      edges(1);
      lit("step_out_e7",  debounced_out, m_out,  4'b0001);
      lit("step_rise_e7", rise_pulse,    m_rise, 4'b0001);
      lit("step_busy_e7", busy,          m_busy, 4'b0000);
      edges(1);
      lit("step_rise_e8", rise_pulse, m_rise, 4'b0000);
      @(negedge clk);
      raw_in[0] = 1'b0;
      edges(6);
      lit("fall_out_e6",  debounced_out, m_out,  4'b0001);
      edges(1);
      lit("fall_out_e7",  debounced_out, m_out,  4'b0000);
      lit("fall_pulse_e7", fall_pulse,   m_fall, 4'b0001);

      // Glitch boundary on channel 1: 4 samples rejected
      @(negedge clk);
      raw_in[1] = 1'b1;
      repeat (4) @(negedge clk);
      raw_in[1] = 1'b0;
      edges(12);
      lit("glitch4_out", debounced_out, m_out, 4'b0000);

      // 5 samples accepted, then the return to low is accepted too
      @(negedge clk);
      raw_in[1] = 1'b1;
      edges(5);
      @(negedge clk);
      raw_in[1] = 1'b0;
      edges(2);
      lit("glitch5_out_e7",  debounced_out, m_out,  4'b0010);
      lit("glitch5_rise_e7", rise_pulse,    m_rise, 4'b0010);
      edges(4);
      lit("glitch5_out_e11", debounced_out, m_out, 4'b0010);
      edges(1);
      lit("glitch5_out_e12",  debounced_out, m_out,  4'b0000);
      lit("glitch5_fall_e12", fall_pulse,    m_fall, 4'b0010);

      // Bounce burst on channel 2: 1,0,1,0 for 2 cycles each, then hold 1
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
         raw_in[2] = (j % 2 == 0);
         repeat (2) @(negedge clk);
      end
      raw_in[2] = 1'b1;
      edges(6);
      lit("bounce_out_e6", debounced_out, m_out, 4'b0000);
      edges(1);
      lit("bounce_out_e7",  debounced_out, m_out,  4'b0100);
      lit("bounce_rise_e7", rise_pulse,    m_rise, 4'b0100);

      // Simultaneous channels
      @(negedge clk);
      raw_in = 4'b0000;
      edges(12);
      @(negedge clk);
      raw_in = 4'b1111;
      edges(6);
      lit("simul_busy_e6", busy,          m_busy, 4'b1111);
      lit("simul_out_e6",  debounced_out, m_out,  4'b0000);
      edges(1);
      lit("simul_out_e7",  debounced_out, m_out,  4'b1111);
      lit("simul_rise_e7", rise_pulse,    m_rise, 4'b1111);
      edges(1);
      lit("simul_rise_e8", rise_pulse, m_rise, 4'b0000);

      // Reset mid-operation: channels 0..2 high, channel 3 counting
      @(negedge clk);
      raw_in = 4'b0000;
      edges(12);
      @(negedge clk);
      raw_in = 4'b0111;
      edges(12);
      @(negedge clk);
      raw_in = 4'b1111;
      edges(3);
      lit("midrst_busy_pre", busy,          m_busy, 4'b1000);
      lit("midrst_out_pre",  debounced_out, m_out,  4'b0111);
      #2 reset_n = 1'b0;
      #1;
      lit("midrst_out",  debounced_out, m_out,  4'b0000);
      lit("midrst_busy", busy,          m_busy, 4'b0000);
      lit("midrst_rise", rise_pulse,    m_rise, 4'b0000);
      lit("midrst_fall", fall_pulse,    m_fall, 4'b0000);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      edges(6);
      lit("postrst_out_e6", debounced_out, m_out, 4'b0000);
      edges(1);
      lit("postrst_out_e7",  debounced_out, m_out,  4'b1111);
      lit("postrst_rise_e7", rise_pulse,    m_rise, 4'b1111);
      edges(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
